// File: rtl/id_ex_if.sv
// id_ex_if: ID->EX decoded fields, forwarding sources, stall/flush and EX-side outputs.
interface id_ex_if #(parameter int BUB_W = 16);
  logic stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [3:0] id_alu_op;
  logic id_asel, id_bsel, id_reg_we, id_mem_we, id_is_branch;
  logic [1:0] id_wb_sel;
  logic [4:0] exm_rd, wb_rd;
  logic exm_we, wb_we;
  logic [31:0] exm_data, wb_data;
  logic ex_valid;
  logic [31:0] ex_pc, ex_imm, alu_a, alu_b, ex_store_data;
  logic [3:0] alu_op;
  logic [4:0] ex_rd;
  logic ex_reg_we, ex_mem_we, ex_is_branch, ex_illegal;
  logic [1:0] ex_wb_sel;
  logic [BUB_W-1:0] bubble_cnt;
  modport master (
    output stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_op, id_asel, id_bsel, id_reg_we, id_mem_we, id_is_branch, id_wb_sel,
           exm_rd, exm_we, exm_data, wb_rd, wb_we, wb_data,
    input  ex_valid, ex_pc, ex_imm, alu_a, alu_b, ex_store_data, alu_op, ex_rd,
           ex_reg_we, ex_mem_we, ex_is_branch, ex_illegal, ex_wb_sel, bubble_cnt
  );
  modport slave (
    input  stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_op, id_asel, id_bsel, id_reg_we, id_mem_we, id_is_branch, id_wb_sel,
           exm_rd, exm_we, exm_data, wb_rd, wb_we, wb_data,
    output ex_valid, ex_pc, ex_imm, alu_a, alu_b, ex_store_data, alu_op, ex_rd,
           ex_reg_we, ex_mem_we, ex_is_branch, ex_illegal, ex_wb_sel, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with stall/flush, operand select and a saturating bubble counter.
// Define ID_EX_FWD_EN to enable EX/MEM and MEM/WB operand forwarding.
module id_ex_stage #(
  parameter logic [3:0] ALU_OP_MAX = 4'hd,
  parameter int BUB_W = 16
) (
  input logic clk,
  input logic rst,
  id_ex_if.slave bus
);
  typedef struct packed {
    logic valid;
    logic [31:0] pc, imm, rs1_data, rs2_data;
    logic [4:0] rs1, rs2, rd;
    logic [3:0] op;
    logic asel, bsel, reg_we, mem_we, is_branch;
    logic [1:0] wb_sel;
    logic illegal;
  } ex_t;
  ex_t r, ld;
  logic [BUB_W-1:0] bub;
  logic ill;
  logic [31:0] fa, fb;
  assign ill = bus.id_alu_op > ALU_OP_MAX;
  always_comb begin
    ld = '0;
    ld.valid = bus.id_valid;
    ld.pc = bus.id_pc;
    ld.imm = bus.id_imm;
    ld.rs1_data = bus.id_rs1_data;
    ld.rs2_data = bus.id_rs2_data;
    ld.rs1 = bus.id_rs1;
    ld.rs2 = bus.id_rs2;
    ld.rd = bus.id_rd;
    ld.op = ill ? 4'd0 : bus.id_alu_op;
    ld.asel = bus.id_asel;
    ld.bsel = bus.id_bsel;
    ld.reg_we = bus.id_reg_we & ~ill;
    ld.mem_we = bus.id_mem_we & ~ill;
    ld.is_branch = bus.id_is_branch;
    ld.wb_sel = bus.id_wb_sel;
    ld.illegal = ill;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r <= '0;
      bub <= '0;
    end else begin
      if (!r.valid && bub != '1) bub <= bub + 1'b1;
      if (bus.flush) r <= '0;
      else if (!bus.stall) r <= ld;
    end
`ifdef ID_EX_FWD_EN
  // EX/MEM is checked first so the younger result wins
  assign fa = (bus.exm_we && bus.exm_rd == r.rs1 && r.rs1 != 5'd0) ? bus.exm_data :
              (bus.wb_we && bus.wb_rd == r.rs1 && r.rs1 != 5'd0) ? bus.wb_data : r.rs1_data;
  assign fb = (bus.exm_we && bus.exm_rd == r.rs2 && r.rs2 != 5'd0) ? bus.exm_data :
              (bus.wb_we && bus.wb_rd == r.rs2 && r.rs2 != 5'd0) ? bus.wb_data : r.rs2_data;
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.exm_rd, bus.exm_we, bus.exm_data, bus.wb_rd, bus.wb_we, bus.wb_data, r.rs1, r.rs2};
  assign fa = r.rs1_data;
  assign fb = r.rs2_data;
`endif
  assign bus.alu_a = r.asel ? r.pc : fa;
  assign bus.alu_b = r.bsel ? r.imm : fb;
  assign bus.ex_store_data = fb;
  assign bus.ex_valid = r.valid;
  assign bus.ex_pc = r.pc;
  assign bus.ex_imm = r.imm;
  assign bus.alu_op = r.op;
  assign bus.ex_rd = r.rd;
  assign bus.ex_reg_we = r.reg_we;
  assign bus.ex_mem_we = r.mem_we;
  assign bus.ex_is_branch = r.is_branch;
  assign bus.ex_wb_sel = r.wb_sel;
  assign bus.ex_illegal = r.illegal;
  assign bus.bubble_cnt = bub;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of load, forwarding, stall, flush, illegal op and bubble saturation.
module tb_id_ex_stage;
`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk, rst;
  int total = 0, bad = 0;
  id_ex_if #(.BUB_W(16)) bus();
  id_ex_stage #(.ALU_OP_MAX(4'hd), .BUB_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    {bus.stall, bus.flush, bus.id_valid, bus.id_pc, bus.id_rs1_data, bus.id_rs2_data, bus.id_imm} = '0;
    {bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_alu_op, bus.id_asel, bus.id_bsel} = '0;
    {bus.id_reg_we, bus.id_mem_we, bus.id_is_branch, bus.id_wb_sel} = '0;
    {bus.exm_rd, bus.exm_we, bus.exm_data, bus.wb_rd, bus.wb_we, bus.wb_data} = '0;
    step();
    chk("rst_valid", 32'(bus.ex_valid), 0);
    chk("rst_op", 32'(bus.alu_op), 0);
    chk("rst_bub", 32'(bus.bubble_cnt), 0);
    chk("rst_a", bus.alu_a, 0);
    rst = 1'b0;
    bus.id_valid = 1; bus.id_rs1 = 1; bus.id_rs2 = 2; bus.id_rd = 4;
    bus.id_rs1_data = 5; bus.id_rs2_data = 7; bus.id_reg_we = 1;
    step();
    chk("add_a", bus.alu_a, 5);
    chk("add_b", bus.alu_b, 7);
    chk("add_op", 32'(bus.alu_op), 0);
    chk("add_valid", 32'(bus.ex_valid), 1);
    chk("add_we", 32'(bus.ex_reg_we), 1);
    chk("add_bub", 32'(bus.bubble_cnt), 1);
    bus.id_rs1 = 3; bus.id_rs1_data = 32'h11;
    bus.exm_rd = 3; bus.exm_we = 1; bus.exm_data = 32'haa;
    bus.wb_rd = 3; bus.wb_we = 1; bus.wb_data = 32'hbb;
    step();
    chk("fwd_exm", bus.alu_a, FWD ? 32'haa : 32'h11);
    bus.exm_we = 0;
    #1;
    chk("fwd_wb", bus.alu_a, FWD ? 32'hbb : 32'h11);
    bus.id_rs1 = 0; bus.id_rs1_data = 32'h22;
    bus.exm_rd = 0; bus.exm_we = 1; bus.wb_rd = 0;
    step();
    chk("fwd_x0", bus.alu_a, 32'h22);
    bus.exm_we = 0;
    bus.id_asel = 1; bus.id_bsel = 1; bus.id_pc = 32'h100; bus.id_imm = 32'h40;
    bus.id_rs2 = 5; bus.id_rs2_data = 32'h77;
    bus.wb_rd = 5; bus.wb_we = 1; bus.wb_data = 32'h99;
    step();
    chk("sel_a", bus.alu_a, 32'h100);
    chk("sel_b", bus.alu_b, 32'h40);
    chk("sel_st", bus.ex_store_data, FWD ? 32'h99 : 32'h77);
    bus.id_asel = 0; bus.id_bsel = 0; bus.id_pc = 32'h200; bus.id_rd = 7;
    bus.id_rs2 = 6; bus.id_rs2_data = 32'h55; bus.wb_rd = 6; bus.wb_data = 0;
    step();
    bus.stall = 1; bus.id_pc = 32'hdead; bus.id_rd = 9; bus.id_rs2_data = 32'h66;
    for (int i = 1; i <= 3; i++) begin
      bus.wb_data = 32'(i);
      step();
      chk("stall_b", bus.alu_b, FWD ? 32'(i) : 32'h55);
      chk("stall_pc", bus.ex_pc, 32'h200);
      chk("stall_rd", 32'(bus.ex_rd), 7);
    end
    bus.flush = 1;
    step();
    chk("fl_valid", 32'(bus.ex_valid), 0);
    chk("fl_we", 32'(bus.ex_reg_we), 0);
    chk("fl_pc", bus.ex_pc, 0);
    chk("fl_b", bus.alu_b, 0);
    chk("fl_bub", 32'(bus.bubble_cnt), 1);
    bus.flush = 0; bus.stall = 0; bus.id_valid = 0;
    step();
    chk("fl_bub_inc", 32'(bus.bubble_cnt), 2);
    bus.id_valid = 1; bus.id_alu_op = 4'hf; bus.id_reg_we = 1; bus.id_mem_we = 1;
    step();
    chk("ill_op", 32'(bus.alu_op), 0);
    chk("ill_flag", 32'(bus.ex_illegal), 1);
    chk("ill_rwe", 32'(bus.ex_reg_we), 0);
    chk("ill_mwe", 32'(bus.ex_mem_we), 0);
    chk("ill_valid", 32'(bus.ex_valid), 1);
    chk("ill_bub", 32'(bus.bubble_cnt), 3);
    bus.id_alu_op = 4'hd;
    step();
    chk("geu_op", 32'(bus.alu_op), 32'hd);
    chk("geu_flag", 32'(bus.ex_illegal), 0);
    chk("geu_we", 32'(bus.ex_reg_we), 1);
    bus.id_valid = 0;
    step();
    chk("sat_start", 32'(bus.bubble_cnt), 3);
    repeat (65541) @(posedge clk);
    #1;
    chk("sat_max", 32'(bus.bubble_cnt), 32'hffff);
    #2 rst = 1;
    #1;
    chk("arst_bub", 32'(bus.bubble_cnt), 0);
    chk("arst_valid", 32'(bus.ex_valid), 0);
    rst = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
